hack_cpu_ctrl: RTL and testbench
================================

# hack_cpu_ctrl

Hack CPU control core that drives the Hack ALU from the other side of its interface. It fetches 16-bit Hack instructions over a valid/ready handshake and decodes A- and C-instructions. It drives the ALU operands and the zx/nx/zy/ny/f/no control bits, and consumes out/zr/ng. It owns the A, D and PC registers and issues data-memory writes. It sits between instruction ROM, data RAM and the existing ALU, which stays a separate, purely combinational instance.

## Interface
- DATA_WIDTH, 16, data word, instruction and A/D register width
- ADDR_WIDTH, 15, PC and data-address width
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- instr_valid_i  in  1  instruction word present on instr_i
- instr_i  in  DATA_WIDTH  instruction at address pc_o
- instr_ready_o  out  1  core accepts instr_i this cycle
- pc_o  out  ADDR_WIDTH  instruction fetch address
- in_m_i  in  DATA_WIDTH  RAM read data at address_m_o (combinational)
- out_m_o  out  DATA_WIDTH  RAM write data
- write_m_o  out  1  RAM write strobe
- address_m_o  out  ADDR_WIDTH  RAM address = A[ADDR_WIDTH-1:0]
- alu_x_o, alu_y_o  out  DATA_WIDTH  ALU operands
- alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o  out  1 each  ALU control bits
- alu_out_i  in  DATA_WIDTH  ALU result
- alu_zr_i, alu_ng_i  in  1 each  ALU zero / negative flags

## Operation
- FSM has two states: FETCH and EXEC. Reset state is FETCH.
- FETCH: instr_ready_o=1. If instr_valid_i=1, latch instr_i into IR and go to EXEC. Otherwise stay in FETCH with PC held (stall of any length).
- EXEC: instr_ready_o=0. Always returns to FETCH after one cycle.
- A-instruction (IR[15]=0): at the end of EXEC, A <= IR and PC <= PC+1. No RAM write. ALU controls stay 0.
- C-instruction (IR[15]=1, IR[14:13] ignored):
  - a=IR[12]; {zx,nx,zy,ny,f,no}=IR[11:6].
  - Destinations: A=IR[5], D=IR[4], M=IR[3].
  - Jump bits: j1/j2/j3=IR[2:0] select lt/eq/gt.
- ALU drive during EXEC of a C-instruction: alu_x_o=D, alu_y_o = a ? in_m_i : A, control bits from IR. In every other case the control bits and operands are driven to 0.
- Writes at the end of EXEC, all using the same-cycle alu_out_i:
  - A <= alu_out_i if dest A.
  - D <= alu_out_i if dest D.
  - write_m_o=1 for the EXEC cycle if dest M, with out_m_o=alu_out_i and address_m_o from the old A.
- Jump taken = (j1&ng) | (j2&zr) | (j3&!ng&!zr), using alu_zr_i/alu_ng_i. If taken, PC <= old A[ADDR_WIDTH-1:0]; otherwise PC <= PC+1.
- PC increments modulo 2^ADDR_WIDTH, so 0x7FFF+1 wraps to 0x0000.
- Simultaneous events: dest A together with a jump uses the pre-update A as the jump target and as the RAM address. Dest AM writes M at the old A.

## Timing
- Each instruction takes exactly 2 cycles (FETCH+EXEC) when instr_valid_i is already high. Each cycle of valid low adds one cycle.
- All registers and the state update on rising clk_i. ALU outputs and write strobes are combinational from IR/state.
- Values after reset and whenever rst_ni=0, asynchronously:
  - A=D=0, PC=0, IR=0, state=FETCH.
  - pc_o=0, instr_ready_o=1.
  - write_m_o=0, out_m_o=0, address_m_o=0.
  - All alu_*_o = 0.
- write_m_o is high for exactly one cycle per M-destination C-instruction.
- Reset asserted mid-EXEC aborts the instruction: no register update, and write_m_o drops immediately.

## Structure
- A shared package hack_pkg holds:
  - the typedef for the state enum {FETCH, EXEC};
  - bit-position constants for the a, c, d and j fields;
  - the struct type alu_ctrl_t {zx,nx,zy,ny,f,no}, reused by the ALU test environment.
- One natural sub-module: hack_jump_unit, combinational, taking j[2:0], zr and ng and returning taken.
- The ALU is not instantiated inside this block. The top level connects it.

## Test plan
- Reset then 0x0005 (@5) → after 2 cycles A=5, PC=1, write_m_o never high.
- @5 followed by 0xEC10 (D=A) → alu_zx..no=110000 in EXEC, then D=5, PC=2.
- D=5 with @100 and 0xE308 (M=D) → one-cycle write_m_o=1, out_m_o=5, address_m_o=100.
- D=5, @20, 0xE301 (D;JGT) → PC=20. Then D=0 with the same sequence → PC = previous PC+1.
- 0xEA87 (0;JMP) with A=0x7FFF → PC=0x7FFF. A following A-instruction wraps PC to 0.
- Hold instr_valid_i low for 4 cycles in FETCH → pc_o is stable and no register changes. Assert rst_ni low during EXEC of M=D → write_m_o=0 immediately and all state returns to 0.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU control core and its ALU environment.
//   - state_t     : control FSM states
//   - field bit positions inside a 16-bit Hack instruction
//   - alu_ctrl_t  : packed ALU control word {zx, nx, zy, ny, f, no}
package hack_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    // Instruction field positions
    localparam int unsigned BIT_CINSTR   = 15;  // 1 = C-instruction
    localparam int unsigned BIT_A        = 12;  // ALU y source: 0 = A, 1 = M
    localparam int unsigned CTRL_MSB     = 11;  // zx
    localparam int unsigned CTRL_LSB     = 6;   // no
    localparam int unsigned BIT_DEST_A   = 5;
    localparam int unsigned BIT_DEST_D   = 4;
    localparam int unsigned BIT_DEST_M   = 3;
    localparam int unsigned JUMP_MSB     = 2;   // j1 (lt)
    localparam int unsigned JUMP_LSB     = 0;   // j3 (gt)

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

endpackage

// File: rtl/hack_jump_unit.sv
// Combinational jump condition evaluation for Hack C-instructions.
// Ports:
//   j_i[2:0]  jump bits {j1 (lt), j2 (eq), j3 (gt)}
//   zr_i      ALU result is zero
//   ng_i      ALU result is negative
//   taken_o   jump condition satisfied
module hack_jump_unit (
    input  logic [2:0] j_i,
    input  logic       zr_i,
    input  logic       ng_i,
    output logic       taken_o
);

    assign taken_o = (j_i[2] & ng_i) | (j_i[1] & zr_i) | (j_i[0] & ~ng_i & ~zr_i);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control core. Fetches instructions over a valid/ready handshake, decodes
// A- and C-instructions, drives an external combinational Hack ALU and issues data
// memory writes. Owns the A, D and PC registers.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   instr_valid_i/instr_i         instruction word at pc_o
//   instr_ready_o                 core accepts instr_i this cycle (FETCH)
//   pc_o                          instruction fetch address
//   in_m_i                        RAM read data at address_m_o
//   out_m_o/write_m_o/address_m_o RAM write data, strobe and address (= A)
//   alu_x_o/alu_y_o               ALU operands (D, and A or M)
//   alu_{zx,nx,zy,ny,f,no}_o      ALU control bits
//   alu_out_i/alu_zr_i/alu_ng_i   ALU result and flags
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_valid_i,
    input  logic [DATA_WIDTH-1:0] instr_i,
    output logic                  instr_ready_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic [DATA_WIDTH-1:0] in_m_i,
    output logic [DATA_WIDTH-1:0] out_m_o,
    output logic                  write_m_o,
    output logic [ADDR_WIDTH-1:0] address_m_o,
    output logic [DATA_WIDTH-1:0] alu_x_o,
    output logic [DATA_WIDTH-1:0] alu_y_o,
    output logic                  alu_zx_o,
    output logic                  alu_nx_o,
    output logic                  alu_zy_o,
    output logic                  alu_ny_o,
    output logic                  alu_f_o,
    output logic                  alu_no_o,
    input  logic [DATA_WIDTH-1:0] alu_out_i,
    input  logic                  alu_zr_i,
    input  logic                  alu_ng_i
);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_ir;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_d;
    logic [ADDR_WIDTH-1:0] r_pc;

    logic                  w_c_exec;
    logic                  w_jump;
    logic                  w_taken;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    alu_ctrl_t             w_ctrl;
    logic                  w_unused_ir;

    // IR[14:13] carry no meaning in a C-instruction
    assign w_unused_ir = ^r_ir[14:13];

    assign w_c_exec = (r_state == EXEC) && r_ir[BIT_CINSTR];
    assign w_pc_inc = r_pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    hack_jump_unit u_jump (
        .j_i     (r_ir[JUMP_MSB:JUMP_LSB]),
        .zr_i    (alu_zr_i),
        .ng_i    (alu_ng_i),
        .taken_o (w_jump)
    );

    assign w_taken = w_c_exec & w_jump;

    // ALU drive is only meaningful while a C-instruction executes; zero otherwise
    always_comb begin
        w_ctrl  = '0;
        alu_x_o = '0;
        alu_y_o = '0;
        if (w_c_exec) begin
            w_ctrl  = alu_ctrl_t'(r_ir[CTRL_MSB:CTRL_LSB]);
            alu_x_o = r_d;
            alu_y_o = r_ir[BIT_A] ? in_m_i : r_a;
        end
    end

    assign alu_zx_o = w_ctrl.zx;
    assign alu_nx_o = w_ctrl.nx;
    assign alu_zy_o = w_ctrl.zy;
    assign alu_ny_o = w_ctrl.ny;
    assign alu_f_o  = w_ctrl.f;
    assign alu_no_o = w_ctrl.no;

    assign write_m_o     = w_c_exec & r_ir[BIT_DEST_M];
    assign out_m_o       = write_m_o ? alu_out_i : '0;
    assign address_m_o   = r_a[ADDR_WIDTH-1:0];
    assign instr_ready_o = (r_state == FETCH);
    assign pc_o          = r_pc;

    // Non-blocking updates mean jump target and RAM address both see the old A
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= FETCH;
            r_ir    <= '0;
            r_a     <= '0;
            r_d     <= '0;
            r_pc    <= '0;
        end else begin
            unique case (r_state)
                FETCH: begin
                    if (instr_valid_i) begin
                        r_ir    <= instr_i;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_state <= FETCH;
                    if (r_ir[BIT_CINSTR]) begin
                        if (r_ir[BIT_DEST_A]) r_a <= alu_out_i;
                        if (r_ir[BIT_DEST_D]) r_d <= alu_out_i;
                        r_pc <= w_taken ? r_a[ADDR_WIDTH-1:0] : w_pc_inc;
                    end else begin
                        r_a  <= r_ir;
                        r_pc <= w_pc_inc;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
module tb_hack_cpu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic [15:0] instr_i = '0;
    logic        instr_ready_o;
    logic [14:0] pc_o;
    logic [15:0] in_m_i;
    logic [15:0] out_m_o;
    logic        write_m_o;
    logic [14:0] address_m_o;
    logic [15:0] alu_x_o, alu_y_o;
    logic        alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o;
    logic [15:0] alu_out_i;
    logic        alu_zr_i, alu_ng_i;

    always #5 clk_i = ~clk_i;

    hack_cpu_ctrl dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .instr_valid_i (instr_valid_i),
        .instr_i       (instr_i),
        .instr_ready_o (instr_ready_o),
        .pc_o          (pc_o),
        .in_m_i        (in_m_i),
        .out_m_o       (out_m_o),
        .write_m_o     (write_m_o),
        .address_m_o   (address_m_o),
        .alu_x_o       (alu_x_o),
        .alu_y_o       (alu_y_o),
        .alu_zx_o      (alu_zx_o),
        .alu_nx_o      (alu_nx_o),
        .alu_zy_o      (alu_zy_o),
        .alu_ny_o      (alu_ny_o),
        .alu_f_o       (alu_f_o),
        .alu_no_o      (alu_no_o),
        .alu_out_i     (alu_out_i),
        .alu_zr_i      (alu_zr_i),
        .alu_ng_i      (alu_ng_i)
    );

    // Reference Hack ALU
    logic [15:0] m_x, m_y, m_o;
    always_comb begin
        m_x = alu_zx_o ? 16'h0 : alu_x_o;
        if (alu_nx_o) m_x = ~m_x;
        m_y = alu_zy_o ? 16'h0 : alu_y_o;
        if (alu_ny_o) m_y = ~m_y;
        m_o = alu_f_o ? (m_x + m_y) : (m_x & m_y);
        if (alu_no_o) m_o = ~m_o;
    end
    assign alu_out_i = m_o;
    assign alu_zr_i  = (m_o == 16'h0);
    assign alu_ng_i  = m_o[15];

    // Small data RAM
    logic [15:0] ram [256];
    assign in_m_i = ram[address_m_o[7:0]];
    int wr_count = 0;
    always @(posedge clk_i) begin
        if (write_m_o) begin
            ram[address_m_o[7:0]] <= out_m_o;
            wr_count <= wr_count + 1;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [14:0] pc;
        logic [15:0] a;
        logic [15:0] d;
        logic        wr;
        logic [15:0] outm;
        logic [14:0] addr;
        logic [5:0]  ctrl;
    } vec_t;

    vec_t vecs [15];

    logic        cap_wr, cap_ready;
    logic [15:0] cap_outm;
    logic [14:0] cap_addr;
    logic [5:0]  cap_ctrl;

    // Present one instruction starting just after a rising edge in FETCH; returns
    // just after the edge that ends EXEC, with EXEC-cycle outputs captured.
    task automatic run_instr(input logic [15:0] ins);
        int guard = 0;
        while (!instr_ready_o && guard < 10) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        if (!instr_ready_o) check("ready_timeout", 32'(instr_ready_o), 32'd1);
        instr_valid_i = 1'b1;
        instr_i       = ins;
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b0;
        cap_wr    = write_m_o;
        cap_ready = instr_ready_o;
        cap_outm  = out_m_o;
        cap_addr  = address_m_o;
        cap_ctrl  = {alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o, alu_no_o};
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vecs[0]  = '{16'h0005, 15'd1,     16'd5,     16'd0, 1'b0, 16'd0, 15'd0,   6'b000000};
        vecs[1]  = '{16'hEC10, 15'd2,     16'd5,     16'd5, 1'b0, 16'd0, 15'd0,   6'b110000};
        vecs[2]  = '{16'h0064, 15'd3,     16'd100,   16'd5, 1'b0, 16'd0, 15'd0,   6'b000000};
        vecs[3]  = '{16'hE308, 15'd4,     16'd100,   16'd5, 1'b1, 16'd5, 15'd100, 6'b001100};
        vecs[4]  = '{16'h0014, 15'd5,     16'd20,    16'd5, 1'b0, 16'd0, 15'd0,   6'b000000};
        vecs[5]  = '{16'hE301, 15'd20,    16'd20,    16'd5, 1'b0, 16'd0, 15'd0,   6'b001100};
        vecs[6]  = '{16'hEA90, 15'd21,    16'd20,    16'd0, 1'b0, 16'd0, 15'd0,   6'b101010};
        vecs[7]  = '{16'h0014, 15'd22,    16'd20,    16'd0, 1'b0, 16'd0, 15'd0,   6'b000000};
        vecs[8]  = '{16'hE301, 15'd23,    16'd20,    16'd0, 1'b0, 16'd0, 15'd0,   6'b001100};
        vecs[9]  = '{16'h7FFF, 15'd24,    16'h7FFF,  16'd0, 1'b0, 16'd0, 15'd0,   6'b000000};
        vecs[10] = '{16'hEA87, 15'h7FFF,  16'h7FFF,  16'd0, 1'b0, 16'd0, 15'd0,   6'b101010};
        vecs[11] = '{16'h0003, 15'd0,     16'd3,     16'd0, 1'b0, 16'd0, 15'd0,   6'b000000};
        vecs[12] = '{16'hE7EF, 15'd3,     16'd1,     16'd0, 1'b1, 16'd1, 15'd3,   6'b011111};
        vecs[13] = '{16'h0064, 15'd4,     16'd100,   16'd0, 1'b0, 16'd0, 15'd0,   6'b000000};
        vecs[14] = '{16'hFC10, 15'd5,     16'd100,   16'd5, 1'b0, 16'd0, 15'd0,   6'b110000};

        // Reset values
        #12;
        check("rst_pc",    32'(pc_o), 32'd0);
        check("rst_ready", 32'(instr_ready_o), 32'd1);
        check("rst_wr",    32'(write_m_o), 32'd0);
        check("rst_outm",  32'(out_m_o), 32'd0);
        check("rst_addr",  32'(address_m_o), 32'd0);
        check("rst_alu",   32'({alu_x_o, alu_y_o, alu_zx_o, alu_nx_o, alu_zy_o,
                                alu_ny_o, alu_f_o, alu_no_o} != '0), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 15; i++) begin
            run_instr(vecs[i].instr);
            check($sformatf("v%0d_ready_exec", i), 32'(cap_ready), 32'd0);
            check($sformatf("v%0d_wr", i), 32'(cap_wr), 32'(vecs[i].wr));
            check($sformatf("v%0d_ctrl", i), 32'(cap_ctrl), 32'(vecs[i].ctrl));
            if (vecs[i].wr) begin
                check($sformatf("v%0d_outm", i), 32'(cap_outm), 32'(vecs[i].outm));
                check($sformatf("v%0d_addr", i), 32'(cap_addr), 32'(vecs[i].addr));
            end
            check($sformatf("v%0d_pc", i), 32'(pc_o), 32'(vecs[i].pc));
            check($sformatf("v%0d_a", i), 32'(address_m_o), 32'(vecs[i].a[14:0]));
            check($sformatf("v%0d_d", i), 32'(dut.r_d), 32'(vecs[i].d));
            check($sformatf("v%0d_wr_fetch", i), 32'(write_m_o), 32'd0);
        end
        check("ram3_after_am", 32'(ram[3]), 32'd1);

        // Stall: valid low for 4 cycles, nothing moves
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("stall%0d_pc", c), 32'(pc_o), 32'd5);
            check($sformatf("stall%0d_ready", c), 32'(instr_ready_o), 32'd1);
            check($sformatf("stall%0d_a", c), 32'(address_m_o), 32'd100);
            check($sformatf("stall%0d_d", c), 32'(dut.r_d), 32'd5);
        end

        // Reset mid-EXEC of M=D aborts the write
        instr_valid_i = 1'b1;
        instr_i       = 16'hE308;
        @(posedge clk_i);
        #1;
        instr_valid_i = 1'b0;
        check("abort_wr_before", 32'(write_m_o), 32'd1);
        check("abort_outm_before", 32'(out_m_o), 32'd5);
        rst_ni = 1'b0;
        #1;
        check("abort_wr", 32'(write_m_o), 32'd0);
        check("abort_outm", 32'(out_m_o), 32'd0);
        check("abort_pc", 32'(pc_o), 32'd0);
        check("abort_addr", 32'(address_m_o), 32'd0);
        check("abort_ready", 32'(instr_ready_o), 32'd1);
        check("abort_d", 32'(dut.r_d), 32'd0);
        check("abort_ctrl", 32'({alu_zx_o, alu_nx_o, alu_zy_o, alu_ny_o, alu_f_o,
                                 alu_no_o}), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        run_instr(16'h0005);
        check("post_rst_pc", 32'(pc_o), 32'd1);
        check("post_rst_a", 32'(address_m_o), 32'd5);
        check("write_pulses", 32'(wr_count), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass,
                 n_total);
        $fatal(1);
    end

endmodule
